bcd_display_driver: RTL and testbench



---
 rtl/bcd_display_driver.sv | 157 +++++++++++++++
 tb/tb_bcd_display_driver.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_driver.sv
// bcd_display_driver: latches a value, converts it to decimal by double-dabble and scans it onto a seven-segment display
// Leading zeros are blanked, a minus sign precedes negative values, and all positions show minus on overflow.
module bcd_display_driver #(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 1024
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  signed_mode,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  busy,
    output logic                  overflow,
    output logic [7:0]            segments,
    output logic [NUM_DIGITS-1:0] digit
);
    localparam int BCD_DIGITS = (DATA_WIDTH + 2) / 3;
    localparam int BW = 4 * BCD_DIGITS;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;
    state_t state, next_state;

    logic                  pend_valid, pend_signed;
    logic [DATA_WIDTH-1:0] pend_data, mag, src_data;
    logic [BW-1:0]         bcd, bcd_adj, bcd_q;
    logic                  neg, sign_q, use_in, start, src_neg;
    logic [CW-1:0]         cnt;
    logic [RW-1:0]         rcnt;
    logic [IW-1:0]         idx;
    logic [7:0]            pats [NUM_DIGITS];
    logic [7:0]            sel;
    int                    c_sig;

    function automatic int sig_of(input logic [BW-1:0] b);
        int s;
        s = 1;
        for (int i = 0; i < BCD_DIGITS; i++)
            if (b[4*i +: 4] != 4'd0) s = i + 1;
        return s;
    endfunction

    function automatic logic [7:0] seg7(input logic [3:0] n);
        case (n)
            4'd0: return 8'h3F;
            4'd1: return 8'h06;
            4'd2: return 8'h5B;
            4'd3: return 8'h4F;
            4'd4: return 8'h66;
            4'd5: return 8'h6D;
            4'd6: return 8'h7D;
            4'd7: return 8'h07;
            4'd8: return 8'h7F;
            4'd9: return 8'h6F;
            default: return 8'h00;
        endcase
    endfunction

    // A queued load is picked up at COMMIT without returning to IDLE; a fresh load in IDLE beats a stale pending one.
    assign use_in   = state == IDLE && load;
    assign start    = (state == IDLE && (load || pend_valid)) || (state == COMMIT && pend_valid);
    assign src_data = use_in ? data : pend_data;
    assign src_neg  = (use_in ? signed_mode : pend_signed) & src_data[DATA_WIDTH-1];

    always_ff @(posedge sys_clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = start ? CONVERT : IDLE;
            CONVERT: next_state = cnt == CW'(DATA_WIDTH - 1) ? COMMIT : CONVERT;
            COMMIT:  next_state = pend_valid ? CONVERT : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb busy = state != IDLE;

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
        assign bcd_adj[4*g +: 4] = bcd[4*g +: 4] >= 4'd5 ? bcd[4*g +: 4] + 4'd3 : bcd[4*g +: 4];
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            pend_valid  <= 1'b0;
            pend_signed <= 1'b0;
            pend_data   <= '0;
            mag         <= '0;
            bcd         <= '0;
            neg         <= 1'b0;
            cnt         <= '0;
            bcd_q       <= '0;
            sign_q      <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (load && state != IDLE) begin
                pend_valid  <= 1'b1;
                pend_data   <= data;
                pend_signed <= signed_mode;
            end else if (start) begin
                pend_valid <= 1'b0;
            end
            if (start) begin
                mag <= src_neg ? -src_data : src_data;
                neg <= src_neg;
                bcd <= '0;
                cnt <= '0;
            end else if (state == CONVERT) begin
                {bcd, mag} <= {bcd_adj, mag} << 1;
                cnt        <= cnt + 1'b1;
            end
            if (state == COMMIT) begin
                bcd_q    <= bcd;
                sign_q   <= neg;
                overflow <= sig_of(bcd) + int'(neg) > NUM_DIGITS;
            end
        end
    end

    assign c_sig = sig_of(bcd_q);

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_pat
        if (g < BCD_DIGITS) begin : g_num
            assign pats[g] = overflow ? 8'h40 : g < c_sig ? seg7(bcd_q[4*g +: 4]) :
                             (g == c_sig && sign_q) ? 8'h40 : 8'h00;
        end else begin : g_blank
            assign pats[g] = (overflow || (g == c_sig && sign_q)) ? 8'h40 : 8'h00;
        end
    end

    always_comb begin
        sel = 8'h00;
        for (int p = 0; p < NUM_DIGITS; p++)
            if (idx == IW'(p)) sel = pats[p];
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            rcnt     <= '0;
            idx      <= '0;
            digit    <= '0;
            segments <= 8'h00;
        end else begin
            rcnt <= rcnt == RW'(REFRESH_DIV - 1) ? '0 : rcnt + 1'b1;
            if (rcnt == RW'(REFRESH_DIV - 1))
                idx <= idx == IW'(NUM_DIGITS - 1) ? '0 : idx + 1'b1;
            digit    <= NUM_DIGITS'(1) << idx;
            segments <= sel;
        end
    end
endmodule

// File: tb/tb_bcd_display_driver.sv
// tb_bcd_display_driver: directed checks of conversion, blanking, sign, overflow, queueing and scan
// Two instances share inputs: a 4-digit and a 2-digit display, both refreshing every 4 clocks.
module tb_bcd_display_driver;
    logic       sys_clk = 1'b0, rst_n = 1'b0, load = 1'b0, signed_mode = 1'b0;
    logic [7:0] data = 8'h00;
    logic       busy, overflow, busy2, overflow2;
    logic [7:0] segments, segments2;
    logic [3:0] digit;
    logic [1:0] digit2;
    logic [7:0] s4 [4];
    logic [7:0] s2 [2];
    int tests = 0, fails = 0;

    typedef struct {
        logic [7:0]  d;
        logic        s;
        logic [31:0] e4;
        logic        o4;
        logic [15:0] e2;
        logic        o2;
    } vec_t;

    always #5 sys_clk = ~sys_clk;

    bcd_display_driver #(.DATA_WIDTH(8), .NUM_DIGITS(4), .REFRESH_DIV(4)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .load(load), .signed_mode(signed_mode), .data(data),
        .busy(busy), .overflow(overflow), .segments(segments), .digit(digit)
    );

    bcd_display_driver #(.DATA_WIDTH(8), .NUM_DIGITS(2), .REFRESH_DIV(4)) dut2 (
        .sys_clk(sys_clk), .rst_n(rst_n), .load(load), .signed_mode(signed_mode), .data(data),
        .busy(busy2), .overflow(overflow2), .segments(segments2), .digit(digit2)
    );

    task automatic pulse(input logic [7:0] d, input logic s);
        data = d;
        signed_mode = s;
        load = 1'b1;
        @(negedge sys_clk);
        load = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || busy2) && n < 200) begin
            @(negedge sys_clk);
            n++;
        end
        tests++;
        if (busy || busy2) begin
            fails++;
            $display("FAIL %s idle timeout: busy=%b busy2=%b, required 0", name, busy, busy2);
        end
    endtask

    task automatic capture();
        s4 = '{default: 8'hEE};
        s2 = '{default: 8'hEE};
        repeat (16) begin
            @(negedge sys_clk);
            for (int p = 0; p < 4; p++) if (digit == 4'(1 << p)) s4[p] = segments;
            for (int p = 0; p < 2; p++) if (digit2 == 2'(1 << p)) s2[p] = segments2;
        end
    endtask

    task automatic test_reset();
        logic [3:0] ed;
        logic [1:0] ed2;
        logic [7:0] es, es2;
        rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        tests++;
        if ({digit, segments, busy, overflow} !== 14'h0) begin
            fails++;
            $display("FAIL reset_state digit=%h seg=%h busy=%b ovf=%b, required all 0", digit, segments, busy, overflow);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge sys_clk);
            ed  = 4'(1 << ((k - 1) / 4));
            es  = k <= 4 ? 8'h3F : 8'h00;
            ed2 = 2'(1 << (((k - 1) / 4) % 2));
            es2 = ((k - 1) / 4) % 2 == 0 ? 8'h3F : 8'h00;
            tests++;
            if (digit !== ed || segments !== es || digit2 !== ed2 || segments2 !== es2) begin
                fails++;
                $display("FAIL scan cycle %0d: digit=%b seg=%h digit2=%b seg2=%h, required %b %h %b %h",
                         k, digit, segments, digit2, segments2, ed, es, ed2, es2);
            end
        end
    endtask

    task automatic test_convert();
        vec_t vecs[$];
        int n;
        vecs.push_back('{8'd42,  1'b0, 32'h0000665B, 1'b0, 16'h665B, 1'b0});
        vecs.push_back('{8'hFF,  1'b1, 32'h00004006, 1'b0, 16'h4006, 1'b0});
        vecs.push_back('{8'h80,  1'b1, 32'h40065B7F, 1'b0, 16'h4040, 1'b1});
        vecs.push_back('{8'hFF,  1'b0, 32'h005B6D6D, 1'b0, 16'h4040, 1'b1});
        vecs.push_back('{8'h00,  1'b1, 32'h0000003F, 1'b0, 16'h003F, 1'b0});
        vecs.push_back('{8'hF6,  1'b1, 32'h0040063F, 1'b0, 16'h4040, 1'b1});
        vecs.push_back('{8'd100, 1'b0, 32'h00063F3F, 1'b0, 16'h4040, 1'b1});
        vecs.push_back('{8'd123, 1'b0, 32'h00065B4F, 1'b0, 16'h4040, 1'b1});
        vecs.push_back('{8'd7,   1'b0, 32'h00000007, 1'b0, 16'h0007, 1'b0});
        foreach (vecs[v]) begin
            pulse(vecs[v].d, vecs[v].s);
            n = 0;
            while (busy && n < 50) begin
                n++;
                @(negedge sys_clk);
            end
            tests++;
            if (n !== 9) begin
                fails++;
                $display("FAIL busy_len data=%h: %0d cycles, required 9", vecs[v].d, n);
            end
            tests++;
            if (overflow !== vecs[v].o4 || overflow2 !== vecs[v].o2) begin
                fails++;
                $display("FAIL overflow data=%h s=%b: %b/%b, required %b/%b", vecs[v].d, vecs[v].s,
                         overflow, overflow2, vecs[v].o4, vecs[v].o2);
            end
            capture();
            for (int p = 0; p < 4; p++) begin
                tests++;
                if (s4[p] !== vecs[v].e4[8*p +: 8]) begin
                    fails++;
                    $display("FAIL seg4 data=%h pos %0d: %h, required %h", vecs[v].d, p, s4[p], vecs[v].e4[8*p +: 8]);
                end
            end
            for (int p = 0; p < 2; p++) begin
                tests++;
                if (s2[p] !== vecs[v].e2[8*p +: 8]) begin
                    fails++;
                    $display("FAIL seg2 data=%h pos %0d: %h, required %h", vecs[v].d, p, s2[p], vecs[v].e2[8*p +: 8]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int n, first_idle;
        logic saw10, saw20;
        n = 0;
        first_idle = -1;
        saw10 = 1'b0;
        saw20 = 1'b0;
        data = 8'd10;
        signed_mode = 1'b0;
        load = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge sys_clk);
            load = i == 2 || i == 4;
            data = i == 2 ? 8'd20 : 8'd30;
            if (busy) n++;
            else if (first_idle < 0) first_idle = i;
            if (digit2 == 2'b10 && segments2 == 8'h06) saw10 = 1'b1;
            if ((digit == 4'b0010 && segments == 8'h5B) || (digit2 == 2'b10 && segments2 == 8'h5B)) saw20 = 1'b1;
        end
        tests++;
        if (n !== 18 || first_idle !== 18) begin
            fails++;
            $display("FAIL b2b_busy: %0d busy cycles ending at %0d, required 18 ending at 18", n, first_idle);
        end
        tests++;
        if (saw10 !== 1'b1 || saw20 !== 1'b0) begin
            fails++;
            $display("FAIL b2b_shown: saw10=%b saw20=%b, required 1 0", saw10, saw20);
        end
        capture();
        tests++;
        if ({s4[3], s4[2], s4[1], s4[0], s2[1], s2[0]} !== 48'h00004F3F_4F3F) begin
            fails++;
            $display("FAIL b2b_final: %h %h %h %h / %h %h, required 00 00 4F 3F / 4F 3F",
                     s4[3], s4[2], s4[1], s4[0], s2[1], s2[0]);
        end
    endtask

    task automatic test_reset_mid();
        int nb;
        pulse(8'd42, 1'b0);
        wait_idle("pre_reset");
        capture();
        tests++;
        if (s4[0] !== 8'h5B || s4[1] !== 8'h66) begin
            fails++;
            $display("FAIL pre_reset 42: %h %h, required 66 5B", s4[1], s4[0]);
        end
        pulse(8'd99, 1'b0);
        pulse(8'd77, 1'b0);
        repeat (2) @(negedge sys_clk);
        rst_n = 1'b0;
        @(negedge sys_clk);
        tests++;
        if ({digit, segments, busy, overflow} !== 14'h0) begin
            fails++;
            $display("FAIL mid_reset digit=%h seg=%h busy=%b ovf=%b, required all 0", digit, segments, busy, overflow);
        end
        rst_n = 1'b1;
        nb = 0;
        repeat (30) begin
            @(negedge sys_clk);
            if (busy || busy2) nb++;
        end
        tests++;
        if (nb !== 0) begin
            fails++;
            $display("FAIL pending_lost: busy %0d cycles after reset, required 0", nb);
        end
        capture();
        tests++;
        if ({s4[3], s4[2], s4[1], s4[0]} !== 32'h0000003F) begin
            fails++;
            $display("FAIL post_reset: %h %h %h %h, required 00 00 00 3F", s4[3], s4[2], s4[1], s4[0]);
        end
        pulse(8'd5, 1'b0);
        wait_idle("load5");
        capture();
        tests++;
        if ({s4[3], s4[2], s4[1], s4[0]} !== 32'h0000006D || overflow !== 1'b0) begin
            fails++;
            $display("FAIL load5: %h %h %h %h ovf=%b, required 00 00 00 6D ovf=0",
                     s4[3], s4[2], s4[1], s4[0], overflow);
        end
    endtask

    initial begin
        test_reset();
        test_convert();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
